digit_serial_addsub: RTL and testbench



---
 rtl/digit_serial_addsub.sv | 134 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle add/subtract/accumulate core, DIGIT bits per
//   active cycle, least-significant digit first, carry registered between digits.
// Latency: done pulses in the cycle after edge E+NDIG (E = start-accept edge);
//   next start is accepted at edge E+NDIG+2 at the earliest.
// Backpressure: ena=0 freezes every register (stalls stretch latency 1:1); start
//   is only sampled in IDLE, so requests made while busy are dropped.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset (reset wins over ena)
//   ena            clock enable for all state
//   start/sub/acc  launch request, subtract select, accumulate select (IDLE only)
//   a, b           WIDTH-bit operands, captured with start
//   busy, done     busy over RUN and DONE; done is a one-cycle result-valid pulse
//   sum/cout/ovf   last completed result, carry (or no-borrow), signed overflow

module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
             WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  // Operand A drains out of the low end one digit per step while the result
  // digits enter at the top, so after NDIG steps this register holds the sum.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;

  // One digit of ripple addition.
  logic [DIGIT:0]   dsum;
  logic [DIGIT-1:0] r_dig;
  logic             c_dig;
  logic             c_msb_in;
  logic [WIDTH-1:0] a_next;

  assign dsum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign r_dig = dsum[DIGIT-1:0];
  assign c_dig = dsum[DIGIT];

  // Carry into the digit's top bit recovered from that bit's sum: s = a ^ b ^ cin.
  // On the last step this is the carry into bit WIDTH-1.
  assign c_msb_in = r_dig[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];

  // Shift right by one digit, result digit enters from the MSB end.
  assign a_next = WIDTH'({r_dig, a_sh} >> DIGIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= acc ? sum : a;
            // Subtraction as A + ~B + 1: invert B now, inject the +1 as carry-in.
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          a_sh  <= a_next;
          b_sh  <= b_sh >> DIGIT;
          carry <= c_dig;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum   <= a_next;
            cout  <= c_dig;
            ovf   <= c_msb_in ^ c_dig;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: randomized and directed checks of digit_serial_addsub
//   at WIDTH/DIGIT = 8/2, 8/8 and 16/4 against an integer-arithmetic model.
// Ports: none (top-level bench); drives on/samples at the falling clock edge.

module tb_digit_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_n, ena, sub, acc;
  // 8/2 instance
  logic       start;
  logic [7:0] a, b, sum;
  logic       busy, done, cout, ovf;
  // 8/8 instance
  logic       start1;
  logic [7:0] a1, b1, sum1;
  logic       busy1, done1, cout1, ovf1;
  // 16/4 instance
  logic        start2;
  logic [15:0] a2, b2, sum2;
  logic        busy2, done2, cout2, ovf2;

  longint model_sum0 = 0;
  longint model_sum2 = 0;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sub(sub), .acc(acc),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .sub(sub), .acc(acc),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .sub(sub), .acc(acc),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_op(input int w, input longint av, input longint bv,
                                 input bit s, output longint r, output bit co, output bit ov);
    longint m, sa, sb, rs;
    m  = longint'(1) << w;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    if (s) begin
      r  = (av - bv + m) % m;
      co = (av >= bv);
      rs = sa - sb;
    end else begin
      r  = (av + bv) % m;
      co = ((av + bv) >= m);
      rs = sa + sb;
    end
    ov = (rs >= m / 2) || (rs < -(m / 2));
  endfunction

  // Launch one op on the 8/2 instance, scramble inputs after capture, and run
  // until it returns to idle. lat = falling edges after accept until done.
  task automatic run0(input logic [7:0] av, input logic [7:0] bv, input bit s, input bit ac,
                      output int lat, output int bcnt);
    @(negedge clk);
    a = av; b = bv; sub = s; acc = ac; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); acc = 1'($urandom);
    lat = -1; bcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy) bcnt++;
      if (done && lat < 0) lat = k;
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic run1(input logic [7:0] av, input logic [7:0] bv, input bit s, output int lat);
    @(negedge clk);
    a1 = av; b1 = bv; sub = s; acc = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (done1 && lat < 0) lat = k;
      if (!busy1) break;
      @(negedge clk);
    end
  endtask

  task automatic run2(input logic [15:0] av, input logic [15:0] bv, input bit s, input bit ac,
                      output int lat);
    @(negedge clk);
    a2 = av; b2 = bv; sub = s; acc = ac; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; a2 = 16'($urandom);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (done2 && lat < 0) lat = k;
      if (!busy2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset_8x2: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
               busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_8x8: got busy=%b done=%b sum=%h, want all zero", busy1, done1, sum1);
    end
    checks++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 20'd0) begin
      errors++;
      $display("FAIL reset_16x4: got busy=%b done=%b sum=%h, want all zero", busy2, done2, sum2);
    end
    ena = 1'b1; rst_n = 1'b1;
    model_sum0 = 0; model_sum2 = 0;
  endtask

  task automatic test_add();
    int lat, bcnt;
    run0(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if (bcnt !== 5) begin errors++; $display("FAIL add_busy_cycles: got %0d want 5", bcnt); end
    checks++;
    if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_result: got sum=%h cout=%b ovf=%b want 96 0 1", sum, cout, ovf);
    end
    model_sum0 = 'h96;
  endtask

  task automatic test_sub_wrap();
    logic [7:0] ta [3] = '{8'h10, 8'h80, 8'hFF};
    logic [7:0] tb [3] = '{8'h20, 8'h01, 8'h01};
    bit         ts [3] = '{1'b1, 1'b1, 1'b0};
    logic [9:0] te [3] = '{{8'hF0, 2'b00}, {8'h7F, 2'b11}, {8'h00, 2'b10}};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      run0(ta[i], tb[i], ts[i], 1'b0, lat, bcnt);
      checks++;
      if ({sum, cout, ovf} !== te[i] || lat !== 4) begin
        errors++;
        $display("FAIL sub_wrap[%0d]: got sum=%h cout=%b ovf=%b lat=%0d want %h %b %b lat=4",
                 i, sum, cout, ovf, lat, te[i][9:2], te[i][1], te[i][0]);
      end
    end
    model_sum0 = 0;
  endtask

  task automatic test_accumulate();
    int lat, bcnt;
    run0(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt);   // sum = 96
    run0(8'h00, 8'h0A, 1'b0, 1'b1, lat, bcnt);
    checks++;
    if ({sum, cout, ovf} !== {8'hA0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL acc_first: got sum=%h cout=%b ovf=%b want A0 0 0", sum, cout, ovf);
    end
    run0(8'h00, 8'h0A, 1'b0, 1'b1, lat, bcnt);
    checks++;
    if ({sum, cout, ovf} !== {8'hAA, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL acc_second: got sum=%h cout=%b ovf=%b want AA 0 0", sum, cout, ovf);
    end
    model_sum0 = 'hAA;
  endtask

  task automatic test_stall_and_ignored_start();
    int lat = -1;
    int busy_seen = 0;
    @(negedge clk);
    a = 8'h33; b = 8'h44; sub = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin lat = k; break; end
      if (k == 1) begin start = 1'b1; a = 8'h01; b = 8'h01; end  // ignored while running
      if (k == 2) begin start = 1'b0; ena = 1'b0; end
      if (k == 5) ena = 1'b1;
      @(negedge clk);
    end
    ena = 1'b1; start = 1'b0;
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", lat); end
    checks++;
    if ({sum, cout, ovf} !== {8'h77, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_result: got sum=%h cout=%b ovf=%b want 77 0 0", sum, cout, ovf);
    end
    ena = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_held_in_stall: got %b want 1", done); end
    ena = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL no_second_op: got %0d busy/done cycles want 0", busy_seen);
    end
    model_sum0 = 'h77;
  endtask

  task automatic test_reset_mid_run();
    int activity = 0;
    int lat, bcnt;
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b want all zero",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    model_sum0 = 0; model_sum2 = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done) activity++;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d active cycles want 0", activity);
    end
    // Accumulate onto the cleared sum: result must be just b.
    run0(8'hEE, 8'h33, 1'b0, 1'b1, lat, bcnt);
    checks++;
    if ({sum, cout, ovf} !== {8'h33, 1'b0, 1'b0} || lat !== 4) begin
      errors++;
      $display("FAIL restart_after_reset: got sum=%h cout=%b ovf=%b lat=%0d want 33 0 0 lat=4",
               sum, cout, ovf, lat);
    end
    model_sum0 = 'h33;
  endtask

  task automatic test_random();
    int lat, bcnt;
    longint r;
    bit co, ov;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] av = 8'($urandom);
      logic [7:0] bv = 8'($urandom);
      bit s  = 1'($urandom);
      bit ac = ($urandom_range(0, 3) == 0);
      ref_op(8, ac ? model_sum0 : longint'(av), longint'(bv), s, r, co, ov);
      run0(av, bv, s, ac, lat, bcnt);
      checks++;
      if ({sum, cout, ovf} !== {8'(r), co, ov} || lat !== 4) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h sub=%b acc=%b: got sum=%h cout=%b ovf=%b lat=%0d want %h %b %b lat=4",
                 i, av, bv, s, ac, sum, cout, ovf, lat, 8'(r), co, ov);
      end
      model_sum0 = r;
    end
  endtask

  task automatic test_param_sweep();
    int lat;
    longint r;
    bit co, ov;
    // 8/8: single-step operation.
    run1(8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h80, 1'b0, 1'b1} || lat !== 1) begin
      errors++;
      $display("FAIL digit_eq_width_add: got sum=%h cout=%b ovf=%b lat=%0d want 80 0 1 lat=1",
               sum1, cout1, ovf1, lat);
    end
    run1(8'h80, 8'h01, 1'b1, lat);
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h7F, 1'b1, 1'b1} || lat !== 1) begin
      errors++;
      $display("FAIL digit_eq_width_sub: got sum=%h cout=%b ovf=%b lat=%0d want 7F 1 1 lat=1",
               sum1, cout1, ovf1, lat);
    end
    // 16/4: four steps.
    run2(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if ({sum2, cout2, ovf2} !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
      errors++;
      $display("FAIL w16_wrap: got sum=%h cout=%b ovf=%b lat=%0d want 0000 1 0 lat=4",
               sum2, cout2, ovf2, lat);
    end
    model_sum2 = 0;
    for (int i = 0; i < 15; i++) begin
      logic [15:0] av = 16'($urandom);
      logic [15:0] bv = 16'($urandom);
      bit s  = 1'($urandom);
      bit ac = 1'($urandom);
      ref_op(16, ac ? model_sum2 : longint'(av), longint'(bv), s, r, co, ov);
      run2(av, bv, s, ac, lat);
      checks++;
      if ({sum2, cout2, ovf2} !== {16'(r), co, ov} || lat !== 4) begin
        errors++;
        $display("FAIL w16_random[%0d] a=%h b=%h sub=%b acc=%b: got sum=%h cout=%b ovf=%b lat=%0d want %h %b %b lat=4",
                 i, av, bv, s, ac, sum2, cout2, ovf2, lat, 16'(r), co, ov);
      end
      model_sum2 = r;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; sub = 1'b0; acc = 1'b0;
    start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_accumulate();
    test_stall_and_ignored_start();
    test_reset_mid_run();
    test_random();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
